dircc_send_handler_multipin: RTL

- Parametrised successor to the single-pin spammer send handler.
- On a send request it reads the device state and selects the lowest-numbered pin whose ready-to-send flag is set.
- For that pin it builds a tick_msg packet, emits it over a valid/ready handshake, and writes the updated state back.
- Sits between the device scheduler (request/state side) and the mux/NoC injection port (packet side). Handles NUM_PINS output pins, serviced one packet per request.

---
 rtl/dircc_application_pkg.sv | 15 +
 rtl/dircc_system_states_pkg.sv | 4 +
 rtl/dircc_types_pkg.sv | 16 +
 rtl/dircc_pin_priority_enc.sv | 16 +
 rtl/dircc_send_handler_multipin.sv | 90 +++++++++
 5 files changed

// File: rtl/dircc_application_pkg.sv
// dircc_application_pkg: application-level packet payload and per-device user state.
package dircc_application_pkg;
  localparam int RTS_MAX = 16;
  localparam int COUNT_BITS = 16;
  typedef struct packed {
    logic [31:0] tick;
    logic [COUNT_BITS-1:0] id;
    logic isDesignatedPacket;
  } tick_msg_t;
  typedef struct packed {
    logic [COUNT_BITS-1:0] count;
    logic isDesignatedSender;
    logic [RTS_MAX-1:0] rts;
  } dev_state_t;
endpackage

// File: rtl/dircc_system_states_pkg.sv
// dircc_system_states_pkg: send handler FSM encoding.
package dircc_system_states_pkg;
  typedef enum logic [1:0] {IDLE, BUILD, SEND, WRITE} send_fsm_t;
endpackage

// File: rtl/dircc_types_pkg.sv
// dircc_types_pkg: system-level packet and device state containers.
package dircc_types_pkg;
  typedef struct packed {
    logic [31:0] address;
    logic [15:0] src;
  } packet_header_t;
  typedef struct packed {
    packet_header_t header;
    dircc_application_pkg::tick_msg_t payload;
  } packet_data_t;
  typedef struct packed {
    logic [31:0] dircc_state;
    logic [31:0] dircc_state_extra;
    dircc_application_pkg::dev_state_t user_state;
  } device_state_t;
endpackage

// File: rtl/dircc_pin_priority_enc.sv
// dircc_pin_priority_enc: index of the lowest set bit of mask, plus an any-set flag.
module dircc_pin_priority_enc #(
  parameter int NUM_PINS = 4,
  parameter int PIN_W = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1
) (
  input  logic [NUM_PINS-1:0] mask,
  output logic [PIN_W-1:0]    index,
  output logic                any_set
);
  always_comb begin
    index = '0;
    for (int i = NUM_PINS - 1; i >= 0; i--)
      if (mask[i]) index = PIN_W'(i);
    any_set = |mask;
  end
endmodule

// File: rtl/dircc_send_handler_multipin.sv
// dircc_send_handler_multipin: services one ready pin per request, emits a tick_msg and writes state back.
// Define DIRCC_SEND_TIMESTAMP_EN to stamp packets with a free-running cycle count.
module dircc_send_handler_multipin
  import dircc_types_pkg::*;
  import dircc_application_pkg::*;
  import dircc_system_states_pkg::*;
#(
  parameter int ADDRESS_MEM_WIDTH = 32,
  parameter int NUM_PINS = 4,
  parameter int PIN_W = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1,
  parameter int COUNT_W = 16,
  parameter logic [15:0] DEVICE_ID = 16'd0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDRESS_MEM_WIDTH-1:0] address,
  input  logic                         send_req,
  output logic                         send_done,
  input  device_state_t                read_state,
  output packet_data_t                 packet_out,
  output logic [PIN_W-1:0]             packet_out_pin,
  output logic                         packet_out_valid,
  input  logic                         packet_out_ready,
  output device_state_t                write_state,
  output logic                         write_state_valid
);
  // COUNT_W narrower than the stored field wraps early via this mask
  localparam logic [COUNT_BITS-1:0] CNT_MASK = COUNT_BITS'((33'd1 << COUNT_W) - 33'd1);
  send_fsm_t state, nxt;
  device_state_t st_q;
  logic [ADDRESS_MEM_WIDTH-1:0] addr_q;
  packet_data_t pkt_q, pkt_d;
  logic [PIN_W-1:0] pin_q, pin;
  logic any_set;
  logic [COUNT_BITS-1:0] cnt_inc;
  logic [31:0] tick;
  dircc_pin_priority_enc #(.NUM_PINS(NUM_PINS), .PIN_W(PIN_W)) u_enc (
    .mask(st_q.user_state.rts[NUM_PINS-1:0]),
    .index(pin),
    .any_set(any_set)
  );
`ifdef DIRCC_SEND_TIMESTAMP_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cyc_q <= '0;
    else cyc_q <= cyc_q + 32'd1;
  assign tick = cyc_q;
`else
  assign tick = 32'd0;
`endif
  assign cnt_inc = (st_q.user_state.count + 1'b1) & CNT_MASK;
  always_comb begin
    pkt_d = '0;
    pkt_d.header.address = 32'(addr_q);
    pkt_d.header.src = DEVICE_ID;
    pkt_d.payload.tick = tick;
    pkt_d.payload.id = st_q.user_state.count;
    pkt_d.payload.isDesignatedPacket = st_q.user_state.isDesignatedSender;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE  ? (send_req ? BUILD : IDLE) :
          state == BUILD ? (any_set ? SEND : WRITE) :
          state == SEND  ? (packet_out_ready ? WRITE : SEND) : IDLE;
    packet_out = pkt_q;
    packet_out_pin = pin_q;
    packet_out_valid = state == SEND;
    write_state_valid = state == WRITE;
    send_done = state == WRITE;
    write_state = state == WRITE ? st_q : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_q <= '0;
      addr_q <= '0;
      pkt_q <= '0;
      pin_q <= '0;
    end else if (state == IDLE && send_req) begin
      st_q <= read_state;
      addr_q <= address;
    end else if (state == BUILD && any_set) begin
      pkt_q <= pkt_d;
      pin_q <= pin;
      st_q.user_state.count <= cnt_inc;
      st_q.user_state.rts <= st_q.user_state.rts & ~(RTS_MAX'(1) << pin);
    end
endmodule
